// File: rtl/sram_port_arbiter_if.sv
// Pipeline-side handshake bundle for the shared SRAM arbiter.
// master = IF/MEM stage logic, slave = the arbiter.
interface sram_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_not_ready;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, mem_not_ready
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, mem_not_ready
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit SRAM between the IF and MEM ports. Each 32-bit access
// becomes a low-half then high-half SRAM access, each held SRAM_WAIT cycles.
// Contention is resolved round-robin against the last served port.
module sram_port_arbiter #(
  parameter int SRAM_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_port_arbiter_if.slave   ports,
  output logic [17:0]          SRAMaddress,
  output logic                 SRAMWEn,
  output logic                 SRAMOE,
  inout  wire  [15:0]          SRAMdata
);

  localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);
  localparam logic G_IF  = 1'b0;
  localparam logic G_MEM = 1'b1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          grant;
  logic          last_grant;
  logic          op_wr;
  logic [16:0]   word_addr;
  logic [15:0]   wdata_hi;
  logic [15:0]   rdata_lo;
  logic          drv;
  logic [15:0]   dout;

  logic          mem_req;
  logic          pick_mem;
  logic          pick_wr;
  logic [16:0]   pick_addr;

  // Only the halfword-index bits of the byte addresses reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ports.if_addr[31:19], ports.if_addr[1:0],
                              ports.mem_addr[31:19], ports.mem_addr[1:0]};

  // Request decode and round-robin pick; rd+wr together counts as a write.
  always_comb begin
    mem_req   = ports.mem_rd | ports.mem_wr;
    pick_mem  = mem_req & (~ports.if_req | (last_grant == G_IF));
    pick_wr   = pick_mem & ports.mem_wr;
    pick_addr = pick_mem ? ports.mem_addr[18:2] : ports.if_addr[18:2];
  end

  assign ports.mem_not_ready = mem_req & ~ports.mem_ready;

  // Bus is driven only through write halves.
  assign SRAMdata = drv ? dout : 16'hzzzz;

  // Access sequencer: latch request in IDLE, walk LOW/HIGH halves, pulse ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      grant           <= G_IF;
      last_grant      <= G_IF;
      op_wr           <= 1'b0;
      word_addr       <= '0;
      wdata_hi        <= '0;
      rdata_lo        <= '0;
      drv             <= 1'b0;
      dout            <= '0;
      SRAMaddress     <= '0;
      SRAMWEn         <= 1'b1;
      SRAMOE          <= 1'b1;
      ports.if_ready  <= 1'b0;
      ports.mem_ready <= 1'b0;
      ports.if_rdata  <= '0;
      ports.mem_rdata <= '0;
    end else begin
      ports.if_ready  <= 1'b0;
      ports.mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (ports.if_req | mem_req) begin
            grant       <= pick_mem;
            op_wr       <= pick_wr;
            word_addr   <= pick_addr;
            wdata_hi    <= ports.mem_wdata[31:16];
            dout        <= ports.mem_wdata[15:0];
            drv         <= pick_wr;
            SRAMaddress <= {pick_addr, 1'b0};
            SRAMOE      <= pick_wr;
            SRAMWEn     <= ~pick_wr;
            cnt         <= '0;
            state       <= LOW;
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            rdata_lo    <= SRAMdata;
            SRAMaddress <= {word_addr, 1'b1};
            dout        <= wdata_hi;
            cnt         <= '0;
            state       <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            SRAMOE  <= 1'b1;
            SRAMWEn <= 1'b1;
            drv     <= 1'b0;
            cnt     <= '0;
            state   <= DONE;
            if (grant == G_MEM) begin
              ports.mem_ready <= 1'b1;
              if (!op_wr) ports.mem_rdata <= {SRAMdata, rdata_lo};
            end else begin
              ports.if_ready <= 1'b1;
              ports.if_rdata <= {SRAMdata, rdata_lo};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Controller that shares the single 16-bit board SRAM between the instruction-fetch port and the data-memory port of the pipelined MIPS core. It converts each 32-bit request into two sequenced 16-bit SRAM accesses and arbitrates round-robin when both ports request. It drives per-port ready and stall indications back into the pipeline. It sits between IF/MEM stage logic and the SRAM pins, and owns the SRAMaddress/SRAMWEn/SRAMOE/SRAMdata bus.

## Interface
- SRAM_WAIT, 2: cycles each 16-bit half is held on the bus, 1..7
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction read request, held until if_ready
- if_addr  in  32  instruction byte address, word aligned
- if_rdata  out  32  instruction word, valid when if_ready
- if_ready  out  1  one-cycle pulse, IF access complete
- mem_rd  in  1  data read request, held until done
- mem_wr  in  1  data write request, held until done
- mem_addr  in  32  data byte address, word aligned
- mem_wdata  in  32  write data, stable while mem_wr
- mem_rdata  out  32  read data, valid when mem_ready
- mem_ready  out  1  one-cycle pulse, MEM access complete
- mem_not_ready  out  1  combinational: (mem_rd|mem_wr) & ~mem_ready; freezes pipeline
- SRAMaddress  out  18  SRAM halfword address
- SRAMWEn  out  1  SRAM write enable, active low
- SRAMOE  out  1  SRAM output enable, active low
- SRAMdata  inout  16  SRAM data bus; driven only during write halves, else Z

## Operation
- States: IDLE, LOW, HIGH, DONE. Registered grant (IF/MEM), op (read/write), wait counter cnt (0..SRAM_WAIT-1), last_grant.
- IDLE: if exactly one port requests, grant it. If both, grant port != last_grant. last_grant resets to IF, so MEM wins first contention. Latch grant, op, address and write data; go LOW, cnt=0.
- mem_rd & mem_wr together: treated as write.
- Address mapping: SRAMaddress = {addr[18:2], half}; half=0 in LOW (bits 15:0), 1 in HIGH (bits 31:16). Outside LOW/HIGH SRAMaddress holds last value (0 after reset).
- LOW/HIGH: hold half for SRAM_WAIT cycles; cnt increments; at cnt==SRAM_WAIT-1 capture SRAMdata into the corresponding rdata half (read) and advance LOW->HIGH->DONE.
- Read halves: SRAMOE=0, SRAMWEn=1, bus Z. Write halves: SRAMOE=1, SRAMWEn=0, bus driven with latched wdata half.
- DONE: granted port's ready=1 for one cycle; last_grant<=grant; next state IDLE. Captured read word appears on the granted port's rdata and holds until that port's next read completes.
- Request withdrawn mid-transaction: transaction completes; ready pulse still issued.
- Inputs are latched in IDLE; later changes have no effect on the current access.

## Timing
- Request first high in cycle 0 with arbiter IDLE: LOW cycles 1..W, HIGH W+1..2W, DONE 2W+1 (ready high), IDLE 2W+2. With W=SRAM_WAIT=2: ready in cycle 5.
- Requester drops request after the ready edge; a new request present in cycle 2W+2 is granted that cycle (back-to-back throughput 2W+2 cycles/word).
- mem_not_ready high from the cycle mem_rd|mem_wr rises through cycle 2W inclusive; low in DONE.
- Reset at any time: next cycle state=IDLE, cnt=0, last_grant=IF, if_ready=mem_ready=0, if_rdata=mem_rdata=0, SRAMaddress=0, SRAMWEn=1, SRAMOE=1, SRAMdata=Z; in-flight access abandoned, no ready pulse.

## Test plan
- Single IF read, W=2, if_addr=0x10, SRAM[8]=0x5678, SRAM[9]=0x1234 -> if_ready pulse in cycle 5, if_rdata=0x12345678, SRAMOE low cycles 1-4, SRAMWEn high throughout.
- MEM write mem_addr=0x400, wdata=0xDEADBEEF -> SRAM[0x200]=0xBEEF, SRAM[0x201]=0xDEAD, SRAMWEn low cycles 1-4, mem_not_ready high cycles 0-4, low in 5.
- if_req and mem_rd both rise cycle 0 after reset -> MEM served first (ready cycle 5), IF granted cycle 6 (ready cycle 11); repeat with both held again -> order alternates.
- Back-to-back MEM reads at 0x0 then 0x4 -> second granted cycle 6, mem_rdata correct each time, no idle gap beyond IDLE cycle.
- rst asserted in cycle 3 of a write -> cycle 4: SRAMWEn=1, SRAMOE=1, bus Z, no mem_ready; SRAM[1] unchanged.
- mem_rd & mem_wr asserted together -> write performed, readback via mem_rd returns written word.
